life_frame_streamer: RTL and testbench
======================================

# life_frame_streamer

Reads the Game-of-Life cell grid back out of the board BRAM and emits it as an AXI4-Stream video frame on `out_stream`. It is the read side of the next-state path: the next-state logic writes rows into BRAM, and this block scans them out as 24-bit RGB pixels. It never starts a frame while a next-state pass is writing. It pulses `frame_done` so the line iterator can start the next generation.

## Interface
- `COLS`, 1280, cells per row (multiple of `WORD_W`)
- `ROWS`, 720, rows per frame
- `WORD_W`, 32, BRAM word width in cells
- `ADDR_W`, 15, BRAM address width (must satisfy 2^ADDR_W ≥ ROWS·COLS/WORD_W)
- `ALIVE_RGB`, 24'hFFFFFF, pixel colour for a live cell
- `DEAD_RGB`, 24'h000000, pixel colour for a dead cell

Ports:
- `out_stream_aclk` in 1 — sole clock
- `periph_resetn` in 1 — asynchronous, active-low reset
- `enable` in 1 — level; frames start only while high
- `calc_busy` in 1 — next-state pass is writing BRAM
- `rd_en` out 1 — BRAM read strobe
- `rd_addr` out ADDR_W — linear word address, row·(COLS/WORD_W)+word
- `rd_data` in WORD_W — valid exactly 1 cycle after `rd_en`
- `out_stream_tdata` out 24 — pixel RGB
- `out_stream_tvalid` out 1
- `out_stream_tready` in 1
- `out_stream_tuser` out 1 — start of frame
- `out_stream_tlast` out 1 — end of line
- `frame_done` out 1 — 1-cycle pulse after the last pixel handshake
- `frame_count` out 16 — present only with `LFS_FRAME_COUNT_EN`

## Operation
- FSM states are IDLE, STREAM and DONE.
- **IDLE → STREAM:** taken when `enable && !calc_busy`. On entry, word address, column and row counters clear and the word FIFO empties.
- **STREAM:** runs the fetch and output logic below.
- **STREAM → DONE:** taken on the handshake (`tvalid && tready`) of the pixel at row ROWS-1, column COLS-1.
- **DONE → IDLE:** unconditional after 1 cycle. `frame_done` = 1 during DONE.
- **Mid-frame changes:** `calc_busy` or `enable` changing during STREAM is ignored; the frame always completes.
- **Fetch:**
  - The block keeps a 2-entry word FIFO.
  - It asserts `rd_en` when (FIFO occupancy + reads in flight) < 2 and words remain in the frame.
  - `rd_addr` increments by 1 per read, from 0 to ROWS·COLS/WORD_W − 1.
  - The FIFO never overflows.
- **Unpack:**
  - The current word is held in a shift register.
  - Bit 0 is the leftmost cell.
  - The next word loads from the FIFO head in the same cycle the last bit of the current word is consumed.
- **Pixel:** `tdata` = `ALIVE_RGB` if the cell bit is 1, otherwise `DEAD_RGB`.
- **`tuser`:** 1 only on the pixel at row 0, column 0.
- **`tlast`:** 1 on every column COLS-1.
- **AXI rules:**
  - While `tvalid && !tready`, `tdata`, `tuser` and `tlast` stay stable.
  - `tvalid` never deasserts without a handshake.
- **Column wrap:** column wraps COLS-1 → 0 with row increment. Row does not wrap; the frame ends.
- **Reset (async assert, any state):**
  - State returns to IDLE and FIFO and counters clear.
  - `rd_en`, `rd_addr`, `tdata`, `tvalid`, `tuser`, `tlast` and `frame_done` all go to 0.
  - `frame_count` goes to 0.
  - After reset release, the next frame starts at address 0 with `tuser`.

## Timing
- **Cycle 0:** first STREAM cycle; `rd_en` = 1, `rd_addr` = 0.
- **Cycle 1:** `rd_data` is captured into the FIFO.
- **Cycle 2:** `tvalid` = 1 with pixel 0.
- **Start latency:** 3 cycles from the IDLE cycle that samples `enable && !calc_busy` to the first `tvalid`.
- **Throughput:** sustained 1 pixel/cycle with `tready` held 1. No bubbles inside a frame, including across word and row boundaries.
- **End of frame:** `frame_done` is high the cycle after the final handshake. The earliest next-frame `tvalid` is 4 cycles after `frame_done`.
- **Backpressure:** fetch stalls when the FIFO is full. There is no read-ahead beyond 2 words.

## Configuration
- **`LFS_FRAME_COUNT_EN` defined:**
  - A 16-bit `frame_count` port is present.
  - It increments in DONE and wraps 16'hFFFF → 0.
  - Reset value is 0.
- **Not defined:** the port and counter are absent. All other behaviour is identical.

## Test plan
Bench parameters: COLS=64, ROWS=4, WORD_W=32, ADDR_W=3.
- **Reset values:** hold `periph_resetn`=0 → all outputs 0. Release with `enable`=0 → no `rd_en` for 100 cycles.
- **All-alive frame:** every word 32'hFFFFFFFF, `tready`=1 →
  - exactly 256 beats, all `tdata`=FFFFFF;
  - `tuser` on beat 0 only;
  - `tlast` on beats 63, 127, 191, 255;
  - `frame_done` pulse one cycle after beat 255;
  - first `tvalid` 3 cycles after start.
- **Bit order:** word 0 = 32'h00000001, others 0 → beat 0 = FFFFFF, beats 1–255 = 000000. Also confirm `rd_addr` sequence 0..7.
- **Backpressure:** random `tready` (50%) → pixel sequence matches the BRAM model, payload is stable during stalls, and there are never more than 2 reads outstanding/buffered.
- **Start interlock:** `enable`=1, `calc_busy`=1 for 50 cycles → no `rd_en`. Drop `calc_busy` → `rd_en` 1 cycle later. Raise `calc_busy` mid-frame → frame still completes with all 256 beats.
- **Reset mid-frame:** assert `periph_resetn`=0 at beat 100 → outputs are 0 in the same cycle. After release, the frame restarts with `tuser` at `rd_addr` 0. With `LFS_FRAME_COUNT_EN`, `frame_count` = 0, then 1 after the next `frame_done`.

Source files
------------

// File: rtl/life_frame_streamer.sv
// Scans the Game-of-Life board out of BRAM as an AXI4-Stream RGB frame.
// Optional feature: define LFS_FRAME_COUNT_EN to add a 16-bit frame_count output.
module life_frame_streamer #(
    parameter int          COLS      = 1280,
    parameter int          ROWS      = 720,
    parameter int          WORD_W    = 32,
    parameter int          ADDR_W    = 15,
    parameter logic [23:0] ALIVE_RGB = 24'hFFFFFF,
    parameter logic [23:0] DEAD_RGB  = 24'h000000
) (
    input  logic              out_stream_aclk,
    input  logic              periph_resetn,
    input  logic              enable,
    input  logic              calc_busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [23:0]       out_stream_tdata,
    output logic              out_stream_tvalid,
    input  logic              out_stream_tready,
    output logic              out_stream_tuser,
    output logic              out_stream_tlast,
    output logic              frame_done
`ifdef LFS_FRAME_COUNT_EN
    ,
    output logic [15:0]       frame_count
`endif
);

    localparam int WORDS = ROWS * COLS / WORD_W;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [ADDR_W:0]  WORDS_CNT = (ADDR_W + 1)'(WORDS);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W:0]    word_cnt_reg;
    logic               rd_pend_reg;
    logic [WORD_W-1:0]  fifo_mem_reg [2];
    logic               fifo_wr_ptr_reg;
    logic               fifo_rd_ptr_reg;
    logic [1:0]         fifo_cnt_reg;
    logic [WORD_W-1:0]  shift_reg;
    logic [BIT_W-1:0]   bit_idx_reg;
    logic               word_valid_reg;
    logic [COL_W-1:0]   col_reg;
    logic [ROW_W-1:0]   row_reg;

    logic               in_stream;
    logic               start;
    logic               handshake;
    logic               last_bit;
    logic               last_beat;
    logic               words_left;
    logic               head_avail;
    logic [WORD_W-1:0]  head_word;
    logic               load;
    logic               push;
    logic               pop;

    assign in_stream  = (state_reg == STREAM);
    assign start      = (state_reg == IDLE) && (state_next == STREAM);
    assign handshake  = word_valid_reg && out_stream_tready;
    assign last_bit   = (bit_idx_reg == BIT_LAST);
    assign last_beat  = handshake && (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign words_left = (word_cnt_reg < WORDS_CNT);

    // Words buffered plus the one in flight never exceed the two FIFO slots.
    assign rd_en   = in_stream && words_left
                     && (({1'b0, fifo_cnt_reg} + {2'b00, rd_pend_reg}) < 3'd2);
    assign rd_addr = word_cnt_reg[ADDR_W-1:0];

    // An empty FIFO lets the arriving BRAM word go straight into the shift register.
    assign head_avail = (fifo_cnt_reg != 2'd0) || rd_pend_reg;
    assign head_word  = (fifo_cnt_reg != 2'd0) ? fifo_mem_reg[fifo_rd_ptr_reg] : rd_data;
    assign load       = in_stream && head_avail && (!word_valid_reg || (handshake && last_bit));
    assign pop        = load && (fifo_cnt_reg != 2'd0);
    assign push       = rd_pend_reg && !(load && (fifo_cnt_reg == 2'd0));

    assign out_stream_tvalid = word_valid_reg;
    assign out_stream_tdata  = word_valid_reg ? (shift_reg[0] ? ALIVE_RGB : DEAD_RGB) : 24'h000000;
    assign out_stream_tuser  = word_valid_reg && (row_reg == '0) && (col_reg == '0);
    assign out_stream_tlast  = word_valid_reg && (col_reg == COL_LAST);
    assign frame_done        = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable && !calc_busy) state_next = STREAM;
            STREAM:  if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (push) fifo_mem_reg[fifo_wr_ptr_reg] <= rd_data;
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_reg       <= IDLE;
            word_cnt_reg    <= '0;
            rd_pend_reg     <= 1'b0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            shift_reg       <= '0;
            bit_idx_reg     <= '0;
            word_valid_reg  <= 1'b0;
            col_reg         <= '0;
            row_reg         <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                word_cnt_reg    <= '0;
                rd_pend_reg     <= 1'b0;
                fifo_wr_ptr_reg <= 1'b0;
                fifo_rd_ptr_reg <= 1'b0;
                fifo_cnt_reg    <= 2'd0;
                bit_idx_reg     <= '0;
                word_valid_reg  <= 1'b0;
                col_reg         <= '0;
                row_reg         <= '0;
            end else if (in_stream) begin
                rd_pend_reg <= rd_en;
                if (rd_en) word_cnt_reg <= word_cnt_reg + 1'b1;
                if (push) fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
                if (pop) fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
                if (push && !pop)
                    fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                else if (pop && !push)
                    fifo_cnt_reg <= fifo_cnt_reg - 2'd1;

                if (load) begin
                    shift_reg      <= head_word;
                    bit_idx_reg    <= '0;
                    word_valid_reg <= 1'b1;
                end else if (handshake) begin
                    shift_reg   <= shift_reg >> 1;
                    bit_idx_reg <= bit_idx_reg + 1'b1;
                    if (last_bit) word_valid_reg <= 1'b0;
                end

                if (handshake) begin
                    if (col_reg == COL_LAST) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
            end
        end
    end

`ifdef LFS_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn)
            frame_count_reg <= 16'd0;
        else if (state_reg == DONE)
            frame_count_reg <= frame_count_reg + 16'd1;
    end

    assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_life_frame_streamer.sv
// Randomized self-checking bench for life_frame_streamer against a per-pixel frame model.
// Build with LFS_FRAME_COUNT_EN defined to also check the frame counter.
module tb_life_frame_streamer;

    localparam int COLS   = 64;
    localparam int ROWS   = 4;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 3;
    localparam int NPIX   = COLS * ROWS;
    localparam int NWORDS = NPIX / WORD_W;

    logic              clk;
    logic              periph_resetn;
    logic              enable;
    logic              calc_busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic [23:0]       tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;
    logic              frame_done;
`ifdef LFS_FRAME_COUNT_EN
    logic [15:0]       frame_count;
`endif

    life_frame_streamer #(
        .COLS(COLS), .ROWS(ROWS), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
        .ALIVE_RGB(24'hFFFFFF), .DEAD_RGB(24'h000000)
    ) dut (
        .out_stream_aclk  (clk),
        .periph_resetn    (periph_resetn),
        .enable           (enable),
        .calc_busy        (calc_busy),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .out_stream_tdata (tdata),
        .out_stream_tvalid(tvalid),
        .out_stream_tready(tready),
        .out_stream_tuser (tuser),
        .out_stream_tlast (tlast),
        .frame_done       (frame_done)
`ifdef LFS_FRAME_COUNT_EN
        ,
        .frame_count      (frame_count)
`endif
    );

    logic [WORD_W-1:0] mem [NWORDS];
    int          errors = 0;
    int          checks = 0;
    int          beats = 0;
    int          issued = 0;
    bit          mon_on = 0;
    bit          done_seen = 0;
    bit          last_prev = 0;
    bit          stall_prev = 0;
    bit          rand_ready = 0;
    logic [31:0] stall_word = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // tready changes just after the active edge so the monitor sees the value used at the next edge
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {tuser, tlast, rgb} for pixel p, straight from the board contents.
    function automatic logic [25:0] exp_pix(input int p);
        logic [WORD_W-1:0] w;
        logic              alive;
        w     = mem[p / WORD_W];
        alive = w[p % WORD_W];
        return {p == 0, (p % COLS) == COLS - 1, alive ? 24'hFFFFFF : 24'h000000};
    endfunction

    task automatic mon_reset();
        beats      = 0;
        issued     = 0;
        done_seen  = 0;
        last_prev  = 0;
        stall_prev = 0;
        mon_on     = 1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (stall_prev)
                check($sformatf("stable_beat%0d", beats), {5'd0, tvalid, tuser, tlast, tdata}, stall_word);
            check("frame_done", frame_done, last_prev);
            if (frame_done) done_seen = 1;
            last_prev = 0;
            if (tvalid && tready) begin
                if (beats < NPIX)
                    check($sformatf("beat%0d", beats), {6'd0, tuser, tlast, tdata}, {6'd0, exp_pix(beats)});
                else
                    check("extra_beat", beats, NPIX - 1);
                if (beats == NPIX - 1) last_prev = 1;
                beats++;
            end
            stall_prev = tvalid && !tready;
            stall_word = {5'd0, 1'b1, tuser, tlast, tdata};
            if (rd_en) begin
                check($sformatf("rd_addr%0d", issued), rd_addr, 32'(issued % NWORDS));
                check("rd_in_frame", issued < NWORDS, 1);
                issued++;
                check("read_ahead", (issued - beats / WORD_W) <= 3, 1);
            end
        end
    end

    task automatic run_frame(input string name, input bit rnd, input int busy_beat);
        int cyc;
        mon_reset();
        rand_ready = rnd;
        calc_busy  = 0;
        enable     = 1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("start_rd_en", rd_en, 1);
                check("start_rd_addr", rd_addr, 0);
                enable = 0;
            end
            check($sformatf("latency_c%0d", i), tvalid, i == 3);
        end
        cyc = 0;
        while (!done_seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (busy_beat >= 0 && beats >= busy_beat) calc_busy = 1;
        end
        check("frame_done_timeout", done_seen, 1);
        check("beat_count", beats, NPIX);
        repeat (8) @(negedge clk);
        check("no_restart", beats, NPIX);
        check("read_total", issued, NWORDS);
        $display("frame %s: beats=%0d reads=%0d cycles=%0d", name, beats, issued, cyc);
        calc_busy  = 0;
        rand_ready = 0;
    endtask

    initial begin
        int cnt;
        int cyc;
        periph_resetn = 0;
        enable        = 0;
        calc_busy     = 0;
        rd_data       = '0;
        for (int i = 0; i < NWORDS; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_outs", {rd_en, rd_addr, tdata, tvalid, tuser, tlast, frame_done}, 0);
`ifdef LFS_FRAME_COUNT_EN
        check("reset_fcount", frame_count, 0);
`endif
        periph_resetn = 1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_en) cnt++;
        end
        check("idle_no_rd_en", cnt, 0);

        for (int i = 0; i < NWORDS; i++) mem[i] = 32'hFFFFFFFF;
        run_frame("all_alive", 0, -1);

        for (int i = 0; i < NWORDS; i++) mem[i] = '0;
        mem[0] = 32'h00000001;
        run_frame("bit_order", 0, -1);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
            run_frame($sformatf("backpressure%0d", f), 1, -1);
        end

        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        enable    = 1;
        calc_busy = 1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd_en) cnt++;
        end
        check("interlock_no_rd_en", cnt, 0);
        run_frame("interlock", 0, 50);

        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        mon_reset();
        calc_busy = 0;
        enable    = 1;
        @(negedge clk);
        enable = 0;
        cyc = 0;
        while (beats < 100 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach", beats >= 100, 1);
        mon_on        = 0;
        periph_resetn = 0;
        #1;
        check("mid_reset_outs", {rd_en, rd_addr, tdata, tvalid, tuser, tlast, frame_done}, 0);
`ifdef LFS_FRAME_COUNT_EN
        check("mid_reset_fcount", frame_count, 0);
`endif
        repeat (3) @(negedge clk);
        periph_resetn = 1;
        @(negedge clk);
        run_frame("after_reset", 1, -1);
`ifdef LFS_FRAME_COUNT_EN
        check("fcount_after_frame", frame_count, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
